// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// R/W bit meaning, and the ACK-slot successor helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG_RX,
    REG_ACK,
    WR_RX,
    WR_ACK,
    RD_LOAD,
    RD_TX,
    RD_MACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam int   I2C_BITS     = 8;
  localparam logic [2:0] I2C_BIT_MSB = 3'(I2C_BITS - 1);

  // Where an ACK slot leads once its 9th SCL clock has ended.
  function automatic i2c_tgt_state_t ack_next_state(input i2c_tgt_state_t cur,
                                                    input logic rw);
    i2c_tgt_state_t nxt;
    nxt = WR_RX;
    if (cur == ADDR_ACK) begin
      if (rw == I2C_RW_READ) nxt = RD_LOAD;
      else if (rw == I2C_RW_WRITE) nxt = REG_RX;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one bus line, with one-clk rise/fall pulses.
// Flops reset to 1 because both I2C lines idle high.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address match, register pointer and bank interface.
// SCL/SDA are oversampled; SDA is only ever pulled low or released.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h20,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       addr_hit
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .reset(reset), .din(scl),
    .dout(scl_s), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .reset(reset), .din(sda),
    .dout(sda_s), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       busy_q, busy_d;
  logic       addr_hit_q, addr_hit_d;
  logic       sda_low_q, sda_low_d;
  logic       rw_q, rw_d;
  logic       load_wait_q, load_wait_d;
  logic       tx_first_q, tx_first_d;

  logic       start_det, stop_det, byte_done;
  logic [7:0] byte_in;

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;
  assign byte_in   = {rx_q, sda_s};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd0);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    busy_d      = busy_q;
    addr_hit_d  = 1'b0;
    sda_low_d   = sda_low_q;
    rw_d        = rw_q;
    load_wait_d = load_wait_q;
    tx_first_d  = tx_first_q;

    // The write strobe carries the old pointer; the pointer moves one clk later.
    if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;

    if ((state_q == ADDR || state_q == REG_RX || state_q == WR_RX) && scl_rise) begin
      rx_d      = byte_in[6:0];
      bit_cnt_d = (bit_cnt_q == 3'd0) ? I2C_BIT_MSB : bit_cnt_q - 3'd1;
    end

    case (state_q)
      ADDR: if (byte_done) begin
        if (byte_in[7:1] == DEV_ADDR) begin
          state_d    = ADDR_ACK;
          rw_d       = byte_in[0];
          addr_hit_d = 1'b1;
          busy_d     = 1'b1;
        end else begin
          state_d = IGNORE;
          busy_d  = 1'b0;
        end
      end
      REG_RX: if (byte_done) begin
        reg_addr_d = byte_in;
        state_d    = REG_ACK;
      end
      WR_RX: if (byte_done) begin
        reg_wdata_d = byte_in;
        reg_we_d    = 1'b1;
        state_d     = WR_ACK;
      end
      // First fall after the 8th bit pulls SDA low; the next fall ends the slot.
      ADDR_ACK, REG_ACK, WR_ACK: if (scl_fall) begin
        if (!sda_low_q) begin
          sda_low_d = 1'b1;
        end else begin
          sda_low_d = 1'b0;
          state_d   = ack_next_state(state_q, rw_q);
        end
      end
      RD_LOAD: begin
        if (!load_wait_q) begin
          load_wait_d = 1'b1;
        end else begin
          load_wait_d = 1'b0;
          tx_d        = reg_rdata;
          tx_first_d  = 1'b1;
          bit_cnt_d   = I2C_BIT_MSB;
          state_d     = RD_TX;
        end
      end
      RD_TX: begin
        if (tx_first_q) begin
          if (!scl_s) begin
            sda_low_d  = ~tx_q[7];
            tx_first_d = 1'b0;
          end
        end else if (scl_fall) begin
          if (bit_cnt_q == 3'd0) begin
            sda_low_d = 1'b0;
            bit_cnt_d = I2C_BIT_MSB;
            state_d   = RD_MACK;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            tx_d      = {tx_q[6:0], 1'b0};
            sda_low_d = ~tx_q[6];
          end
        end
      end
      RD_MACK: if (scl_rise) begin
        reg_addr_d = reg_addr_q + 8'd1;
        if (!sda_s) begin
          state_d = RD_LOAD;
        end else begin
          state_d = IGNORE;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase

    if (stop_det || start_det) begin
      state_d     = stop_det ? IDLE : ADDR;
      bit_cnt_d   = I2C_BIT_MSB;
      sda_low_d   = 1'b0;
      reg_we_d    = 1'b0;
      addr_hit_d  = 1'b0;
      load_wait_d = 1'b0;
      tx_first_d  = 1'b0;
      if (stop_det) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= I2C_BIT_MSB;
      rx_q        <= '0;
      tx_q        <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      addr_hit_q  <= 1'b0;
      sda_low_q   <= 1'b0;
      rw_q        <= I2C_RW_WRITE;
      load_wait_q <= 1'b0;
      tx_first_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      busy_q      <= busy_d;
      addr_hit_q  <= addr_hit_d;
      sda_low_q   <= sda_low_d;
      rw_q        <= rw_d;
      load_wait_q <= load_wait_d;
      tx_first_q  <= tx_first_d;
    end
  end

  assign sda       = sda_low_q ? 1'b0 : 1'bz;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign busy      = busy_q;
  assign addr_hit  = addr_hit_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: behavioural open-drain master at clk/16,
// read-only bank model, and write/read scoreboards.
module tb_i2c_target;

  localparam int Q = 40;
  localparam int H = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_low;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, busy, addr_hit;

  logic [7:0]  bank [256];
  logic [15:0] we_q [$];
  logic [7:0]  rd_q [$];
  logic [15:0] exp_we;
  int total = 0;
  int bad = 0;
  int hit_count = 0;
  int we_count = 0;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  assign reg_rdata = bank[reg_addr];

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h20), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda_bus),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy), .addr_hit(addr_hit)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_val, input logic scl_val, input logic low_val);
    reset = rst_val;
    scl   = scl_val;
    m_low = low_val;
  endtask

  // Write strobes are matched in order against the expected {addr, data} queue.
  always @(negedge clk) begin
    if (addr_hit) hit_count++;
    if (reg_we) begin
      we_count++;
      checkOutput("we_expected", 8'(we_q.size() != 0), 8'h01);
      if (we_q.size() != 0) begin
        exp_we = we_q.pop_front();
        checkOutput("we_addr", reg_addr, exp_we[15:8]);
        checkOutput("we_data", reg_wdata, exp_we[7:0]);
      end
    end
  end

  task automatic bit_out(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #H; scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; ack = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; #Q; scl = 1'b1; #Q; b[i] = sda_bus; #Q; scl = 1'b0; #Q;
    end
    bit_out(mack);
    m_low = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    for (int i = 0; i < 256; i++) bank[i] = 8'(i ^ 8'h96);
    bank[8'h10] = 8'hC3;
    bank[8'h11] = 8'h7E;

    applyStimulus(1'b1, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #18;
    checkOutput("rst_sda", 8'(sda_bus), 8'h01);
    checkOutput("rst_reg_addr", reg_addr, 8'h00);
    checkOutput("rst_reg_we", 8'(reg_we), 8'h00);
    checkOutput("rst_busy", 8'(busy), 8'h00);
    checkOutput("rst_addr_hit", 8'(addr_hit), 8'h00);
    #10 reset = 1'b1;
    #100;

    // Test 1: simple register write.
    $display("[TB] test 1: write 0x5A to 0x10");
    i2c_start();
    write_byte(8'h40, ack); checkOutput("t1_ack_addr", 8'(ack), 8'h00);
    write_byte(8'h10, ack); checkOutput("t1_ack_reg", 8'(ack), 8'h00);
    we_q.push_back({8'h10, 8'h5A});
    write_byte(8'h5A, ack); checkOutput("t1_ack_data", 8'(ack), 8'h00);
    checkOutput("t1_busy_before_stop", 8'(busy), 8'h01);
    i2c_stop();
    checkOutput("t1_busy_after_stop", 8'(busy), 8'h00);
    checkOutput("t1_reg_addr", reg_addr, 8'h11);
    checkOutput("t1_we_count", 8'(we_count), 8'd1);

    // Test 2: pointer write, repeated START, read two bytes.
    $display("[TB] test 2: read 0x10..0x11 via repeated start");
    i2c_start();
    write_byte(8'h40, ack); checkOutput("t2_ack_addr", 8'(ack), 8'h00);
    write_byte(8'h10, ack); checkOutput("t2_ack_reg", 8'(ack), 8'h00);
    i2c_start();
    write_byte(8'h41, ack); checkOutput("t2_ack_raddr", 8'(ack), 8'h00);
    rd_q.push_back(8'hC3);
    rd_q.push_back(8'h7E);
    read_byte(1'b0, rd); checkOutput("t2_rd0", rd, rd_q.pop_front());
    read_byte(1'b1, rd); checkOutput("t2_rd1", rd, rd_q.pop_front());
    i2c_stop();
    checkOutput("t2_reg_addr", reg_addr, 8'h12);
    checkOutput("t2_busy", 8'(busy), 8'h00);

    // Test 3: foreign address is ignored.
    $display("[TB] test 3: address 0x42 ignored");
    i2c_start();
    write_byte(8'h42, ack); checkOutput("t3_nack_addr", 8'(ack), 8'h01);
    checkOutput("t3_busy", 8'(busy), 8'h00);
    write_byte(8'h10, ack); checkOutput("t3_nack_reg", 8'(ack), 8'h01);
    write_byte(8'h55, ack); checkOutput("t3_nack_data", 8'(ack), 8'h01);
    i2c_stop();
    checkOutput("t3_hit_count", 8'(hit_count), 8'd3);
    checkOutput("t3_we_count", 8'(we_count), 8'd1);
    checkOutput("t3_reg_addr", reg_addr, 8'h12);

    // Test 4: pointer wraps from 0xFF to 0x00.
    $display("[TB] test 4: pointer wrap");
    i2c_start();
    write_byte(8'h40, ack); checkOutput("t4_ack_addr", 8'(ack), 8'h00);
    write_byte(8'hFF, ack); checkOutput("t4_ack_reg", 8'(ack), 8'h00);
    we_q.push_back({8'hFF, 8'hAA});
    write_byte(8'hAA, ack); checkOutput("t4_ack_d0", 8'(ack), 8'h00);
    we_q.push_back({8'h00, 8'hBB});
    write_byte(8'hBB, ack); checkOutput("t4_ack_d1", 8'(ack), 8'h00);
    i2c_stop();
    checkOutput("t4_reg_addr", reg_addr, 8'h01);
    checkOutput("t4_we_count", 8'(we_count), 8'd3);

    // Test 5: STOP in the middle of a data byte.
    $display("[TB] test 5: STOP after 4 data bits");
    i2c_start();
    write_byte(8'h40, ack); checkOutput("t5_ack_addr", 8'(ack), 8'h00);
    write_byte(8'h20, ack); checkOutput("t5_ack_reg", 8'(ack), 8'h00);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    i2c_stop();
    #H;
    checkOutput("t5_we_count", 8'(we_count), 8'd3);
    checkOutput("t5_busy", 8'(busy), 8'h00);
    checkOutput("t5_sda", 8'(sda_bus), 8'h01);
    checkOutput("t5_reg_addr", reg_addr, 8'h20);

    // Test 6: reset while the target holds the ACK low.
    $display("[TB] test 6: reset during ACK");
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_out(((8'h40 >> i) & 8'h01) != 8'h00);
    m_low = 1'b0;
    checkOutput("t6_ack_driven", 8'(sda_bus), 8'h00);
    reset = 1'b0;
    #1;
    checkOutput("t6_sda_released", 8'(sda_bus), 8'h01);
    checkOutput("t6_reg_addr", reg_addr, 8'h00);
    checkOutput("t6_reg_wdata", reg_wdata, 8'h00);
    checkOutput("t6_reg_we", 8'(reg_we), 8'h00);
    checkOutput("t6_busy", 8'(busy), 8'h00);
    checkOutput("t6_addr_hit", 8'(addr_hit), 8'h00);
    #19 reset = 1'b1;
    #Q;
    i2c_stop();
    i2c_start();
    write_byte(8'h40, ack); checkOutput("t6_ack_addr", 8'(ack), 8'h00);
    write_byte(8'h33, ack); checkOutput("t6_ack_reg", 8'(ack), 8'h00);
    we_q.push_back({8'h33, 8'h99});
    write_byte(8'h99, ack); checkOutput("t6_ack_data", 8'(ack), 8'h00);
    i2c_stop();
    checkOutput("t6_we_count", 8'(we_count), 8'd4);
    checkOutput("t6_reg_addr_end", reg_addr, 8'h34);
    checkOutput("final_hit_count", 8'(hit_count), 8'd7);
    checkOutput("final_we_pending", 8'(we_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
